// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues each masked ALU function code in ascending order; `ALU_SEQ_LOOP_EN adds Loop
module alu_op_sequencer #(
  parameter int NUM_OPS = 16,
  parameter int FUN_WD  = 4,
  parameter int ACK_TO  = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic [NUM_OPS-1:0] Op_Mask,
  input  logic               Tx_Busy,
`ifdef ALU_SEQ_LOOP_EN
  input  logic               Loop,
`endif
  output logic [FUN_WD-1:0]  ALU_FUN,
  output logic               ALU_Enable,
  output logic               CLKG_EN,
  output logic               Seq_Busy,
  output logic               Seq_Done
);

  localparam int PW = $clog2(NUM_OPS + 1);
  localparam int AW = $clog2(ACK_TO + 1);
  localparam logic [PW-1:0] PTR_END  = PW'(NUM_OPS);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TO - 1);

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT_ACK, WAIT_IDLE, DONE} state_t;

  state_t             state;
  state_t             nxt;
  logic [NUM_OPS-1:0] mask_r;
  logic [PW-1:0]      ptr;
  logic [AW-1:0]      ack_cnt;
  logic               hit;
  logic [FUN_WD-1:0]  hit_idx;
  logic               reload;
  logic               loop_req;

`ifdef ALU_SEQ_LOOP_EN
  assign loop_req = Loop;
`else
  assign loop_req = 1'b0;
`endif

  // Lowest set mask bit at or above ptr; descending loop leaves the lowest winner.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (mask_r[i] && (i >= int'(ptr))) begin
        hit     = 1'b1;
        hit_idx = FUN_WD'(i);
      end
    end
  end

  always_comb begin
    nxt    = state;
    reload = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          nxt    = SCAN;
          reload = 1'b1;
        end
      end
      SCAN: begin
        if (hit) begin
          nxt = ISSUE;
        end else if (loop_req && (|Op_Mask)) begin
          nxt    = SCAN;
          reload = 1'b1;
        end else begin
          nxt = DONE;
        end
      end
      ISSUE: nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (Tx_Busy || (ack_cnt == ACK_LAST)) nxt = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!Tx_Busy) begin
          if (ptr != PTR_END) begin
            nxt = SCAN;
          end else if (loop_req && (|Op_Mask)) begin
            nxt    = SCAN;
            reload = 1'b1;
          end else begin
            nxt = DONE;
          end
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      mask_r     <= '0;
      ptr        <= '0;
      ack_cnt    <= '0;
      ALU_FUN    <= '0;
      ALU_Enable <= 1'b0;
      CLKG_EN    <= 1'b0;
      Seq_Busy   <= 1'b0;
      Seq_Done   <= 1'b0;
    end else begin
      state <= nxt;
      if (reload) begin
        mask_r <= Op_Mask;
        ptr    <= '0;
      end
      if ((state == SCAN) && hit) ALU_FUN <= hit_idx;
      if (state == ISSUE) begin
        ptr     <= PW'(ALU_FUN) + PW'(1);
        ack_cnt <= '0;
      end else if (state == WAIT_ACK) begin
        ack_cnt <= ack_cnt + AW'(1);
      end
      ALU_Enable <= (nxt == ISSUE);
      CLKG_EN    <= (nxt == ISSUE) || (nxt == WAIT_ACK) || (nxt == WAIT_IDLE);
      Seq_Busy   <= (nxt != IDLE);
      Seq_Done   <= (nxt == DONE);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench: expected issue/done events queued by stimulus, popped by monitor
module tb_alu_op_sequencer;

  localparam int DONE_CODE = 99;

  typedef struct {
    int code;
    int at;
  } ev_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start;
  logic [15:0] Op_Mask;
  logic        Tx_Busy;
  logic [3:0]  ALU_FUN;
  logic        ALU_Enable;
  logic        CLKG_EN;
  logic        Seq_Busy;
  logic        Seq_Done;
`ifdef ALU_SEQ_LOOP_EN
  logic        loop = 1'b0;
`endif

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];
  ev_t  m_e;
  int   m_code;

  alu_op_sequencer #(.NUM_OPS(16), .FUN_WD(4), .ACK_TO(8)) dut (
`ifdef ALU_SEQ_LOOP_EN
    .Loop(loop),
`endif
    .CLK(CLK),
    .RST(RST),
    .Start(Start),
    .Op_Mask(Op_Mask),
    .Tx_Busy(Tx_Busy),
    .ALU_FUN(ALU_FUN),
    .ALU_Enable(ALU_Enable),
    .CLKG_EN(CLKG_EN),
    .Seq_Busy(Seq_Busy),
    .Seq_Done(Seq_Done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int code, input int at);
    ev_t e;
    e.code = code;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic go_to(input int target);
    while (cyc < target) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic start_pass(input logic [15:0] m, output int c);
    Op_Mask = m;
    Start   = 1'b1;
    c       = cyc;
    @(posedge CLK);
    #1;
    Start = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (ALU_Enable || Seq_Done) begin
      m_code = Seq_Done ? DONE_CODE : int'(ALU_FUN);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got code %0d at cycle %0d, expected none", m_code, cyc);
      end else begin
        m_e = exp_q.pop_front();
        check("event_code", m_code, m_e.code);
        check("event_cycle", cyc, m_e.at);
      end
    end
  end

  initial begin
    int c;
    int c2;
    RST = 1'b1; Start = 1'b0; Op_Mask = '0; Tx_Busy = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_alu_fun", int'(ALU_FUN), 0);
    check("rst_enable", int'(ALU_Enable), 0);
    check("rst_clkg", int'(CLKG_EN), 0);
    check("rst_busy", int'(Seq_Busy), 0);
    check("rst_done", int'(Seq_Done), 0);
    RST = 1'b0;
    go_to(cyc + 2);

    // single op with a 3-cycle Tx_Busy acknowledge
    start_pass(16'h0001, c);
    push(0, c + 2);
    push(DONE_CODE, c + 8);
    go_to(c + 3); Tx_Busy = 1'b1;
    go_to(c + 6); Tx_Busy = 1'b0;
    go_to(c + 10);
    check("s1_drained", exp_q.size(), 0);

    // four ops, every acknowledge times out
    start_pass(16'h8421, c);
    push(0, c + 2);
    push(5, c + 13);
    push(10, c + 24);
    push(15, c + 35);
    push(DONE_CODE, c + 45);
    check("s2_scan_clkg", int'(CLKG_EN), 0);
    check("s2_scan_busy", int'(Seq_Busy), 1);
    go_to(c + 3);
    check("s2_wait_clkg", int'(CLKG_EN), 1);
    go_to(c + 47);
    check("s2_drained", exp_q.size(), 0);
    check("s2_idle_busy", int'(Seq_Busy), 0);

    // empty mask
    start_pass(16'h0000, c);
    push(DONE_CODE, c + 2);
    go_to(c + 4);
    check("s3_drained", exp_q.size(), 0);

    // mask change and second Start mid-pass are ignored
    start_pass(16'h0006, c);
    push(1, c + 2);
    push(2, c + 13);
    push(DONE_CODE, c + 24);
    go_to(c + 5); Op_Mask = 16'hFFFF; Start = 1'b1;
    go_to(c + 6); Start = 1'b0;
    go_to(c + 27);
    check("s4_drained", exp_q.size(), 0);
    Op_Mask = '0;

    // reset in WAIT_IDLE of the second op, with a coincident Start
    start_pass(16'h00FF, c);
    push(0, c + 2);
    push(1, c + 13);
    go_to(c + 22);
    check("s5_pre_fun", int'(ALU_FUN), 1);
    check("s5_pre_clkg", int'(CLKG_EN), 1);
    RST = 1'b1; Start = 1'b1;
    go_to(c + 23);
    check("s5_rst_fun", int'(ALU_FUN), 0);
    check("s5_rst_enable", int'(ALU_Enable), 0);
    check("s5_rst_clkg", int'(CLKG_EN), 0);
    check("s5_rst_busy", int'(Seq_Busy), 0);
    check("s5_rst_done", int'(Seq_Done), 0);
    RST = 1'b0; Start = 1'b0;
    go_to(c + 25);
    check("s5_start_ignored", int'(Seq_Busy), 0);
    check("s5_drained", exp_q.size(), 0);

    start_pass(16'h00FF, c2);
    for (int k = 0; k < 8; k++) push(k, c2 + 2 + 11 * k);
    push(DONE_CODE, c2 + 90);
    go_to(c2 + 93);
    check("s5_restart_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter NUM_OPS, default 16: number of ALU operations selectable, range 2..2**FUN_WD.
REQ-002 SHALL have parameter FUN_WD, default 4: ALU function code width.
REQ-003 SHALL have parameter ACK_TO, default 8: maximum cycles to wait for Tx_Busy to rise after an issue, range >= 1.
REQ-004 SHALL have port CLK  in  1: single clock; all logic on the rising edge.
REQ-005 SHALL have port RST  in  1: synchronous, active-high reset.
REQ-006 SHALL have port Start  in  1: single-cycle request to begin a sequence pass.
REQ-007 SHALL have port Op_Mask  in  NUM_OPS: bit i set means operation i is issued; sampled only when a pass starts.
REQ-008 SHALL have port Tx_Busy  in  1: downstream transmitter busy.
REQ-009 SHALL have port ALU_FUN  out  FUN_WD: function code of the current or last issued operation.
REQ-010 SHALL have port ALU_Enable  out  1: one-cycle issue strobe.
REQ-011 SHALL have port CLKG_EN  out  1: ALU clock-gate enable.
REQ-012 SHALL have port Seq_Busy  out  1: a pass is in progress.
REQ-013 SHALL have port Seq_Done  out  1: one-cycle pulse at the end of a pass.

Function
REQ-014 SHALL implement the states IDLE, SCAN, ISSUE, WAIT_ACK, WAIT_IDLE and DONE, with all outputs registered or decoded from registered state only.
REQ-015 IDLE: on Start=1, SHALL load mask_r<=Op_Mask and ptr<=0, then go to SCAN; Start is ignored in every other state.
REQ-016 SCAN: SHALL take exactly one cycle.
- If mask_r has a set bit at index >= ptr, the lowest such index SHALL be loaded into ALU_FUN and the FSM SHALL go to ISSUE.
- Otherwise the FSM SHALL go to DONE.
REQ-017 ISSUE: SHALL assert ALU_Enable=1 for exactly this one cycle, set ptr<=ALU_FUN+1, clear the ack counter and go to WAIT_ACK.
REQ-018 WAIT_ACK:
- Tx_Busy=1 SHALL go to WAIT_IDLE.
- If Tx_Busy is not seen within ACK_TO cycles, the FSM SHALL go to WAIT_IDLE when the counter reaches ACK_TO.
REQ-019 WAIT_IDLE: SHALL remain while Tx_Busy=1.
- When Tx_Busy=0 and ptr==NUM_OPS, the FSM SHALL go to DONE.
- When Tx_Busy=0 otherwise, the FSM SHALL go to SCAN.
REQ-020 DONE: SHALL assert Seq_Done=1 for exactly one cycle, then go to IDLE.
REQ-021 Seq_Busy SHALL be 1 in every state except IDLE; CLKG_EN SHALL be 1 in ISSUE, WAIT_ACK and WAIT_IDLE, and 0 otherwise.
REQ-022 Zero mask: Start with Op_Mask=0 SHALL give IDLE->SCAN->DONE with no ALU_Enable, and Seq_Done 2 cycles after Start.
REQ-023 Latency: the first ALU_Enable SHALL occur 2 cycles after Start; back-to-back ops with Tx_Busy already low SHALL be spaced by WAIT_ACK timeout + 3 cycles.
REQ-024 ptr SHALL be $clog2(NUM_OPS+1) bits wide and never wrap; bit NUM_OPS-1 is the last index checked.
REQ-025 Changes on Op_Mask during a pass SHALL have no effect until the next pass.
REQ-026 ALU_FUN SHALL hold its value outside SCAN updates and SHALL never exceed NUM_OPS-1.

Reset
REQ-027 RST=1 at any clock edge SHALL force IDLE, with ALU_FUN=0, ALU_Enable=0, CLKG_EN=0, Seq_Busy=0, Seq_Done=0, mask_r=0, ptr=0 and ack counter=0.
REQ-028 Reset mid-pass SHALL abort the pass with no Seq_Done pulse; Start coincident with RST SHALL be ignored.

Configuration
REQ-029 Macro ALU_SEQ_LOOP_EN, when defined, SHALL add input port Loop (1 bit).
- When a pass would go to DONE and Loop=1, the block SHALL instead reload mask_r<=Op_Mask and ptr<=0, go to SCAN and emit no Seq_Done.
- If the reloaded mask is zero, the block SHALL go to DONE.
REQ-030 When ALU_SEQ_LOOP_EN is undefined, the Loop port SHALL be absent and behaviour SHALL equal Loop=0.

Verification
REQ-031 Directed scenarios:
- Op_Mask=16'h0001, Tx_Busy pulse high 3 cycles starting 1 cycle after ALU_Enable -> single ALU_Enable with ALU_FUN=0, then Seq_Done.
- Op_Mask=16'h8421, Tx_Busy held 0, ACK_TO=8 -> ALU_Enable with ALU_FUN=0, 5, 10, 15 in order, then one Seq_Done.
- Op_Mask=0 -> no ALU_Enable, Seq_Done exactly 2 cycles after Start.
- Op_Mask=16'h0006, Op_Mask changed to 16'hFFFF mid-pass, second Start during pass -> only codes 1, 2 issued, one Seq_Done.
- RST=1 asserted in WAIT_IDLE of Op_Mask=16'h00FF pass -> all outputs at reset values next cycle, no Seq_Done, a new Start restarts at code 0.
- ALU_SEQ_LOOP_EN defined, Loop=1, Op_Mask=16'h0003 -> codes 0, 1, 0, 1, ... repeat; dropping Loop=0 -> Seq_Done after the current pass.
